red_match_sched: RTL and testbench
==================================

# red_match_sched

Round-robin scheduler that shares one registered proximity comparator among `NUM_REQ` red-detection channels. Each channel submits a pair of 10-bit coordinates. The block grants one channel at a time and drives the pair onto the comparator inputs. It waits out the comparator's registered latency, then returns the match bit to the granted channel with a one-cycle done pulse. It sits between the per-channel red-detect coordinate stages and the shared comparator instance.

## Interface
- `NUM_REQ`, 4: number of requesting channels, 2..8.
- `DATA_W`, 10: coordinate width.
- `CMP_LATENCY`, 1: CLK edges from the comparator sampling its inputs to `equal` being valid; range 1..7.

- `CLK`  in  1  single clock; all state updates on posedge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `REQ`  in  NUM_REQ  per-channel request level.
- `REQ_A`  in  NUM_REQ*DATA_W  packed coordinate A; channel i occupies bits [i*DATA_W+DATA_W-1 : i*DATA_W].
- `REQ_B`  in  NUM_REQ*DATA_W  packed coordinate B; same packing.
- `GNT`  out  NUM_REQ  one-hot, one-cycle pulse when a channel's pair is accepted.
- `DONE`  out  NUM_REQ  one-hot, one-cycle pulse; same index as the preceding `GNT`.
- `RESULT`  out  1  match bit; valid with `DONE`, held until the next `DONE`.
- `BUSY`  out  1  high in every state except IDLE.
- `CMP_A`  out  DATA_W  registered; drives comparator `Data_in_A`.
- `CMP_B`  out  DATA_W  registered; drives comparator `Data_in_B`.
- `CMP_EQUAL`  in  1  comparator `equal` output.

## Operation
- States: IDLE, WAIT, CAPTURE.
- **Reset** (`RESET_N`=0, asynchronous): state IDLE; `GNT`, `DONE`, `RESULT`, `BUSY` = 0; `CMP_A`, `CMP_B` = 0; round-robin pointer = 0; latency counter = 0.
- **IDLE, no REQ bit set:** outputs hold; `GNT` and `DONE` = 0.
- **IDLE, any REQ bit set:**
  - Select the first set bit searching from the pointer upward, wrapping at `NUM_REQ`-1 to 0.
  - Register that channel's `REQ_A`/`REQ_B` into `CMP_A`/`CMP_B`.
  - Pulse `GNT[i]`; record index i.
  - Pointer = (i+1) mod `NUM_REQ`.
  - Counter = `CMP_LATENCY`; next state WAIT.
- **WAIT:** counter decrements each edge. On the edge where the counter equals 1, go to CAPTURE.
- **CAPTURE:** register `RESULT` = `CMP_EQUAL`; pulse `DONE[i]`; return to IDLE.
- `CMP_A`/`CMP_B` hold their value from grant until the next grant.
- Coordinates are sampled only on the grant edge. Later changes to `REQ_A`/`REQ_B` do not affect the result.
- `REQ` is a level. A channel still requesting after its `DONE` is re-arbitrated as a new request.
- REQ activity while `BUSY` is ignored; no queueing beyond the level itself.
- Pair contents are not interpreted: A=100 or B=0 pairs are issued normally and the comparator's 0 result is returned.
- Pointer wrap: after granting index `NUM_REQ`-1, the pointer is 0.

## Timing
- Grant edge e0: `GNT`, `CMP_A`, `CMP_B`, `BUSY` update.
- The comparator samples at e1 and `equal` is valid after edge e(`CMP_LATENCY`).
- `DONE`/`RESULT` register at edge e0+`CMP_LATENCY`+1.
- IDLE is re-entered at that same edge. The earliest next `GNT` is edge e0+`CMP_LATENCY`+2.
- Throughput: one comparison per `CMP_LATENCY`+2 cycles.
- `GNT` and `DONE` are never high in the same cycle. Each is high for exactly one cycle per transaction.
- `BUSY` is high from e0 through the cycle ending at the `DONE` edge. It is low in the cycle `DONE` is high.
- Reset mid-transaction: the transaction is aborted and no `DONE` is issued, even when reset releases before the expected `DONE` edge. The first post-reset grant goes to the lowest-index requester.

## Test plan
1. **Reset:** hold `RESET_N`=0 with `REQ`=4'b1111 → all outputs 0 throughout; the first grant after release is `GNT`=4'b0001.
2. **Single request, real comparator, `CMP_LATENCY`=1:** ch0 A=300, B=250 → `GNT`[0] at e0, `CMP_A`=300, `CMP_B`=250, `DONE`[0] at e0+2 with `RESULT`=1. Repeat with A=700, B=250 → `RESULT`=0. Repeat with A=300, B=0 → `RESULT`=0.
3. **Saturation:** `REQ`=4'b1111 held → grant order 0,1,2,3,0, grants 3 cycles apart; each `DONE` index matches its grant.
4. **Fairness:** after ch2 is served, raise ch1 and ch3 → ch3 is granted first, then ch1.
5. **Latency parameter:** with `CMP_LATENCY`=3, a bench comparator model makes `CMP_EQUAL`=1 only in the cycle before edge e0+4 → `DONE` at e0+4 with `RESULT`=1. Change `REQ_A` at e0+1 → `CMP_A` is unchanged.
6. **Reset during WAIT:** pulse `RESET_N` low at e0+1 → `BUSY`, `CMP_A`, `CMP_B` drop to 0 immediately; no `DONE` ever pulses for that transaction; the pointer restarts at 0.

Source files
------------

// File: rtl/red_match_sched.sv
`default_nettype none
// ============================================================================
// Module   : red_match_sched
// Purpose  : Round-robin scheduler sharing one registered proximity
//            comparator among NUM_REQ red-detection channels. The block grants
//            one channel, registers its coordinate pair onto the comparator
//            inputs, waits out the comparator latency, then returns the match
//            bit with a one-cycle DONE pulse on the granted index.
// Ports    : CLK, RESET_N     clock / asynchronous active-low reset
//            REQ              per-channel request level
//            REQ_A, REQ_B     packed per-channel coordinates (DATA_W each)
//            GNT, DONE        one-hot single-cycle pulses
//            RESULT           match bit, valid with DONE, held until next DONE
//            BUSY             high whenever the scheduler is not idle
//            CMP_A, CMP_B     registered comparator operands
//            CMP_EQUAL        comparator match output
// Revision : 1.0 - initial release
// ============================================================================
module red_match_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 10,
    parameter int CMP_LATENCY = 1
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [NUM_REQ-1:0]          REQ,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_A,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_B,
    output logic [NUM_REQ-1:0]          GNT,
    output logic [NUM_REQ-1:0]          DONE,
    output logic                        RESULT,
    output logic                        BUSY,
    output logic [DATA_W-1:0]           CMP_A,
    output logic [DATA_W-1:0]           CMP_B,
    input  logic                        CMP_EQUAL
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] c_lat      = CNT_W'(CMP_LATENCY);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                result_q, result_d;
    logic [DATA_W-1:0]   cmp_a_q, cmp_a_d;
    logic [DATA_W-1:0]   cmp_b_q, cmp_b_d;

    // Round-robin search: first requester at or above the pointer, wrapping.
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand_idx;
    int                  cand_sum;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        cand_sum  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = int'(ptr_q) + k;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand_idx = IDX_W'(cand_sum);
            if (!sel_found && REQ[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        done_d   = '0;
        result_d = result_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    // Operands are sampled only here; later input changes are ignored.
                    cmp_a_d = REQ_A[int'(sel_idx)*DATA_W +: DATA_W];
                    cmp_b_d = REQ_B[int'(sel_idx)*DATA_W +: DATA_W];
                    gnt_d   = NUM_REQ'(1) << sel_idx;
                    idx_d   = sel_idx;
                    ptr_d   = (sel_idx == c_last_idx) ? '0 : sel_idx + 1'b1;
                    cnt_d   = c_lat;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == c_cnt_one) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // CMP_EQUAL is valid in the cycle leading into this edge.
                result_d = CMP_EQUAL;
                done_d   = NUM_REQ'(1) << idx_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= 1'b0;
            cmp_a_q  <= '0;
            cmp_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
        end
    end

    assign GNT    = gnt_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign BUSY   = (state_q != ST_IDLE);
    assign CMP_A  = cmp_a_q;
    assign CMP_B  = cmp_b_q;

endmodule
`default_nettype wire

// File: tb/tb_red_match_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_red_match_sched
// Purpose  : Self-checking bench for red_match_sched. One instance uses
//            CMP_LATENCY=1 with a registered proximity comparator model and a
//            scoreboard; a second instance uses CMP_LATENCY=3 with a
//            hand-timed comparator output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_red_match_sched;

    localparam int N = 4;
    localparam int W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Latency-1 instance
    logic [N-1:0]   req1, gnt1, done1;
    logic [N*W-1:0] a1, b1;
    logic           res1, busy1, eq1;
    logic [W-1:0]   ca1, cb1;

    // Latency-3 instance
    logic [N-1:0]   req3, gnt3, done3;
    logic [N*W-1:0] a3, b3;
    logic           res3, busy3, eq3;
    logic [W-1:0]   ca3, cb3;

    red_match_sched #(.NUM_REQ(N), .DATA_W(W), .CMP_LATENCY(1)) u_dut1 (
        .CLK(clk), .RESET_N(rst_n), .REQ(req1), .REQ_A(a1), .REQ_B(b1),
        .GNT(gnt1), .DONE(done1), .RESULT(res1), .BUSY(busy1),
        .CMP_A(ca1), .CMP_B(cb1), .CMP_EQUAL(eq1)
    );

    red_match_sched #(.NUM_REQ(N), .DATA_W(W), .CMP_LATENCY(3)) u_dut3 (
        .CLK(clk), .RESET_N(rst_n), .REQ(req3), .REQ_A(a3), .REQ_B(b3),
        .GNT(gnt3), .DONE(done3), .RESULT(res3), .BUSY(busy3),
        .CMP_A(ca3), .CMP_B(cb3), .CMP_EQUAL(eq3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Proximity comparator: match when |A-B| <= 64, never for A=100 or B=0.
    function automatic logic prox(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return (a != 10'd100) && (b != 10'd0) && (d <= 10'd64);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) eq1 <= 1'b0;
        else        eq1 <= prox(ca1, cb1);
    end

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    typedef struct {
        int           idx;
        logic         res;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    exp_t inflight;
    exp_t e_mon;
    bit   have_inflight = 1'b0;
    int   gnt_cyc = 0;

    task automatic set_ch(input int idx, input int a, input int b);
        a1[idx*W +: W] = W'(a);
        b1[idx*W +: W] = W'(b);
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx = idx;
        e.a   = a1[idx*W +: W];
        e.b   = b1[idx*W +: W];
        e.res = prox(e.a, e.b);
        exp_q.push_back(e);
    endtask

    // A reset aborts the transaction in flight; no DONE may follow it.
    always @(negedge rst_n) have_inflight = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt1 != '0 && done1 != '0) check("gnt_done_overlap", 32'(done1), 32'(0));
            if (gnt1 != '0) begin
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt1), 32'(0));
                end else begin
                    e_mon = exp_q.pop_front();
                    check("gnt_idx",   32'(gnt1),  32'(oh(e_mon.idx)));
                    check("gnt_cmp_a", 32'(ca1),   32'(e_mon.a));
                    check("gnt_cmp_b", 32'(cb1),   32'(e_mon.b));
                    check("gnt_busy",  32'(busy1), 32'(1));
                    inflight      = e_mon;
                    have_inflight = 1'b1;
                    gnt_cyc       = cyc;
                end
            end
            if (done1 != '0) begin
                if (!have_inflight) begin
                    check("done_unexpected", 32'(done1), 32'(0));
                end else begin
                    check("done_idx",    32'(done1),         32'(oh(inflight.idx)));
                    check("done_result", 32'(res1),          32'(inflight.res));
                    check("done_lat",    32'(cyc - gnt_cyc), 32'(2));
                    check("done_busy",   32'(busy1),         32'(0));
                    have_inflight = 1'b0;
                end
            end
        end
    end

    task automatic wait_gnt(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt1 == '0 && n < 20);
        check("gnt_timeout", 32'(gnt1 != '0), 32'(1));
        c = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || have_inflight || busy1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 40), 32'(1));
    endtask

    initial begin
        int c[5];
        int gc;
        int n;
        int ta[3];
        int tbv[3];
        ta  = '{300, 700, 300};
        tbv = '{250, 250, 0};

        req1 = '0; a1 = '0; b1 = '0;
        req3 = '0; a3 = '0; b3 = '0; eq3 = 1'b0;
        set_ch(0, 300, 250);
        set_ch(1, 700, 250);
        set_ch(2, 300, 0);
        set_ch(3, 400, 380);

        // Reset held with all channels requesting: everything stays at zero.
        req1 = 4'b1111;
        repeat (4) begin
            @(negedge clk);
            check("rst_gnt",   32'(gnt1),  32'(0));
            check("rst_done",  32'(done1), 32'(0));
            check("rst_busy",  32'(busy1), 32'(0));
            check("rst_res",   32'(res1),  32'(0));
            check("rst_cmp_a", 32'(ca1),   32'(0));
            check("rst_cmp_b", 32'(cb1),   32'(0));
        end

        // Saturation: order 0,1,2,3,0 with grants three cycles apart.
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) wait_gnt(c[i]);
        req1 = '0;
        for (int i = 1; i < 5; i++) check("sat_gap", 32'(c[i] - c[i-1]), 32'(3));
        wait_idle();

        // Single requests on channel 0 with different pairs.
        for (int i = 0; i < 3; i++) begin
            set_ch(0, ta[i], tbv[i]);
            push_exp(0);
            req1 = 4'b0001;
            wait_gnt(gc);
            req1 = '0;
            wait_idle();
        end

        // Fairness: after ch2, ch3 wins over ch1.
        push_exp(2);
        req1 = 4'b0100;
        wait_gnt(gc);
        req1 = '0;
        wait_idle();
        push_exp(3); push_exp(1);
        req1 = 4'b1010;
        wait_gnt(gc);
        wait_gnt(gc);
        req1 = '0;
        wait_idle();

        // Reset during WAIT: abort, outputs clear at once, pointer back to 0.
        push_exp(1);
        req1 = 4'b0010;
        wait_gnt(gc);
        req1 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(busy1), 32'(0));
        check("abort_cmp_a", 32'(ca1),   32'(0));
        check("abort_cmp_b", 32'(cb1),   32'(0));
        check("abort_gnt",   32'(gnt1),  32'(0));
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", 32'(done1), 32'(0));
        end
        push_exp(1); push_exp(3);
        req1 = 4'b1010;
        wait_gnt(gc);
        wait_gnt(gc);
        req1 = '0;
        wait_idle();

        // Latency-3 instance: equal is high only in the cycle before e0+4.
        a3[W-1:0] = 10'd123;
        b3[W-1:0] = 10'd456;
        req3 = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt3 == '0 && n < 20);
        check("l3_gnt",   32'(gnt3), 32'(4'b0001));
        check("l3_cmp_a", 32'(ca3),  32'(123));
        req3 = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("l3_wait_done",  32'(done3), 32'(0));
            check("l3_wait_busy",  32'(busy3), 32'(1));
            check("l3_hold_cmp_a", 32'(ca3),   32'(123));
            if (k == 1) a3[W-1:0] = 10'd999;
            if (k == 3) eq3 = 1'b1;
        end
        @(posedge clk);
        #1 eq3 = 1'b0;
        @(negedge clk);
        check("l3_done",   32'(done3), 32'(4'b0001));
        check("l3_result", 32'(res3),  32'(1));
        check("l3_busy",   32'(busy3), 32'(0));
        @(negedge clk);
        check("l3_done_pulse", 32'(done3), 32'(0));
        check("l3_result_hold", 32'(res3), 32'(1));
        check("l3_cmp_a_final", 32'(ca3),  32'(123));
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
